// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single physical-memory line port between the L1 I-cache and D-cache.
// Optional build macro ARB_RR_EN: round-robin priority between the two sides on contention.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t            state_q;
    logic              pmem_read_q, pmem_write_q;
    logic [ADDR_W-1:0] pmem_addr_q;
    logic [LINE_W-1:0] pmem_wdata_q;

    logic i_pend, d_pend, prio_d, grant_d, grant_i;

    assign i_pend  = i_read;
    assign d_pend  = d_read | d_write;
    assign grant_d = (state_q == IDLE) && d_pend && (!i_pend || prio_d);
    assign grant_i = (state_q == IDLE) && i_pend && !grant_d;

`ifdef ARB_RR_EN
    // prio_d_q=1 means D wins the next contended grant; it moves to the loser.
    logic prio_d_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prio_d_q <= 1'b1;
        else if (state_q == IDLE && d_pend && i_pend)
            prio_d_q <= ~grant_d;
    end
    assign prio_d = prio_d_q;
`else
    assign prio_d = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_addr_q  <= '0;
            pmem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q      <= SERVE_D;
                        pmem_addr_q  <= d_addr;
                        pmem_write_q <= d_write;
                        pmem_read_q  <= ~d_write;
                        pmem_wdata_q <= d_write ? d_wdata : '0;
                    end else if (grant_i) begin
                        state_q      <= SERVE_I;
                        pmem_addr_q  <= i_addr;
                        pmem_write_q <= 1'b0;
                        pmem_read_q  <= 1'b1;
                        pmem_wdata_q <= '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    // Returning to IDLE forces a turnaround cycle so the owner can drop its request.
                    if (pmem_resp) begin
                        state_q      <= IDLE;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pmem_read  = pmem_read_q;
    assign pmem_write = pmem_write_q;
    assign pmem_addr  = pmem_addr_q;
    assign pmem_wdata = pmem_wdata_q;

    assign i_resp  = (state_q == SERVE_I) && pmem_resp;
    assign d_resp  = (state_q == SERVE_D) && pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus randomized traffic against a grant model.
// Inputs are driven and outputs sampled at the falling clock edge.
module tb_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_addr;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    int checks = 0;
    int errors = 0;

    cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        return {r[31:5], 5'b0};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic test_reset();
        #3;
        checks++;
        if ({pmem_read, pmem_write, pmem_addr, pmem_wdata, i_resp, d_resp} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rd=%0b wr=%0b addr=%h ir=%0b dr=%0b want all 0",
                     pmem_read, pmem_write, pmem_addr, i_resp, d_resp);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_i_read();
        logic [LW-1:0] a5 = {32{8'hA5}};
        i_read = 1'b1;
        i_addr = 32'h0000_0060;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({pmem_read, pmem_write, pmem_addr, d_resp, i_resp} !== {1'b1, 1'b0, 32'h60, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL i_read_strobe cyc%0d got rd=%0b wr=%0b addr=%h want rd=1 wr=0 addr=60",
                         c, pmem_read, pmem_write, pmem_addr);
            end
        end
        @(negedge clk);
        pmem_rdata = a5;
        pmem_resp  = 1'b1;
        #1;
        checks++;
        if ({i_resp, d_resp, i_rdata} !== {1'b1, 1'b0, a5}) begin
            errors++;
            $display("FAIL i_read_resp got ir=%0b dr=%0b rdata=%h want ir=1 dr=0 rdata=%h",
                     i_resp, d_resp, i_rdata, a5);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        i_read    = 1'b0;
        #1;
        checks++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0) begin
            errors++;
            $display("FAIL i_read_done got rd=%0b wr=%0b ir=%0b want all 0", pmem_read, pmem_write, i_resp);
        end
    endtask

    task automatic test_d_write_hold();
        logic [LW-1:0] wd = {8{32'h1234_5678}};
        d_write = 1'b1;
        d_addr  = 32'h0000_1000;
        d_wdata = wd;
        @(negedge clk);
        d_addr  = 32'h0000_2000;
        d_wdata = ~wd;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({pmem_read, pmem_write, pmem_addr, pmem_wdata} !== {1'b0, 1'b1, 32'h1000, wd}) begin
                errors++;
                $display("FAIL d_write_hold cyc%0d got rd=%0b wr=%0b addr=%h wdata=%h want wr=1 addr=1000",
                         c, pmem_read, pmem_write, pmem_addr, pmem_wdata);
            end
            @(negedge clk);
        end
        pmem_resp = 1'b1;
        #1;
        checks++;
        if ({d_resp, i_resp} !== 2'b10) begin
            errors++;
            $display("FAIL d_write_resp got dr=%0b ir=%0b want dr=1 ir=0", d_resp, i_resp);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        d_write   = 1'b0;
    endtask

    task automatic test_both_pending();
        logic [AW-1:0] exp2;
        i_read = 1'b1; i_addr = 32'h0000_0080;
        d_read = 1'b1; d_addr = 32'h0000_3000;
        @(negedge clk);
        checks++;
        if ({pmem_read, pmem_addr} !== {1'b1, 32'h3000}) begin
            errors++;
            $display("FAIL both_d_first got rd=%0b addr=%h want rd=1 addr=3000", pmem_read, pmem_addr);
        end
        pmem_resp = 1'b1;
        #1;
        checks++;
        if ({d_resp, i_resp} !== 2'b10) begin
            errors++;
            $display("FAIL both_d_resp got dr=%0b ir=%0b want dr=1 ir=0", d_resp, i_resp);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        d_read    = 1'b0;
        checks++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            errors++;
            $display("FAIL both_turnaround got rd=%0b wr=%0b want 0 0", pmem_read, pmem_write);
        end
        @(negedge clk);
        checks++;
        if ({pmem_read, pmem_addr} !== {1'b1, 32'h80}) begin
            errors++;
            $display("FAIL both_i_second got rd=%0b addr=%h want rd=1 addr=80", pmem_read, pmem_addr);
        end
        pmem_resp = 1'b1;
        #1;
        checks++;
        if ({d_resp, i_resp} !== 2'b01) begin
            errors++;
            $display("FAIL both_i_resp got dr=%0b ir=%0b want dr=0 ir=1", d_resp, i_resp);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        i_read = 1'b1; i_addr = 32'h0000_00A0;
        d_read = 1'b1; d_addr = 32'h0000_5000;
`ifdef ARB_RR_EN
        exp2 = 32'h0000_00A0;
`else
        exp2 = 32'h0000_5000;
`endif
        @(negedge clk);
        checks++;
        if ({pmem_read, pmem_addr} !== {1'b1, exp2}) begin
            errors++;
            $display("FAIL both_second_pair got rd=%0b addr=%h want rd=1 addr=%h", pmem_read, pmem_addr, exp2);
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        if (exp2 == 32'h0000_5000) d_read = 1'b0; else i_read = 1'b0;
        @(negedge clk);
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        i_read = 1'b0;
        d_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rw_both();
        d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_6000; d_wdata = {LW{1'b1}};
        @(negedge clk);
        checks++;
        if ({pmem_read, pmem_write, pmem_addr, pmem_wdata} !== {1'b0, 1'b1, 32'h6000, {LW{1'b1}}}) begin
            errors++;
            $display("FAIL rw_both got rd=%0b wr=%0b addr=%h want rd=0 wr=1 addr=6000",
                     pmem_read, pmem_write, pmem_addr);
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        d_read = 1'b0; d_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_resp();
        pmem_resp = 1'b1;
        #1;
        checks++;
        if ({i_resp, d_resp} !== 2'b00) begin
            errors++;
            $display("FAIL idle_resp got ir=%0b dr=%0b want 0 0", i_resp, d_resp);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        checks++;
        if ({pmem_read, pmem_write, pmem_addr} !== {2'b00, 32'h6000}) begin
            errors++;
            $display("FAIL idle_hold got rd=%0b wr=%0b addr=%h want 0 0 6000", pmem_read, pmem_write, pmem_addr);
        end
        i_read = 1'b1; i_addr = 32'h0000_0100;
        @(negedge clk);
        checks++;
        if ({pmem_read, pmem_addr} !== {1'b1, 32'h100}) begin
            errors++;
            $display("FAIL idle_then_grant got rd=%0b addr=%h want rd=1 addr=100", pmem_read, pmem_addr);
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        i_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        d_read = 1'b1; d_addr = 32'h0000_4000;
        @(negedge clk);
        checks++;
        if ({pmem_read, pmem_addr} !== {1'b1, 32'h4000}) begin
            errors++;
            $display("FAIL rst_mid_grant got rd=%0b addr=%h want rd=1 addr=4000", pmem_read, pmem_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pmem_read, pmem_write, pmem_addr} !== '0) begin
            errors++;
            $display("FAIL rst_mid_async got rd=%0b wr=%0b addr=%h want all 0", pmem_read, pmem_write, pmem_addr);
        end
        @(negedge clk);
        d_read = 1'b0;
        rst_n  = 1'b1;
        pmem_resp = 1'b1;
        #1;
        checks++;
        if ({i_resp, d_resp} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_stale_resp got ir=%0b dr=%0b want 0 0", i_resp, d_resp);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        checks++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_after got rd=%0b wr=%0b want 0 0", pmem_read, pmem_write);
        end
    endtask

    // Model: each IDLE sample grants the sole pending side, or the pointer's side on contention.
    task automatic test_random(input int rounds);
        bit            ptr_d = 1'b1;
        bit            both, win_d, exp_w;
        int            kind;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_wd, rd;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < rounds; r++) begin
            if (!i_read && $urandom_range(0, 1) == 1) begin
                i_read = 1'b1; i_addr = rand_addr();
            end
            if (!d_read && !d_write && $urandom_range(0, 1) == 1) begin
                kind = $urandom_range(0, 2);
                d_read = (kind != 1); d_write = (kind != 0);
                d_addr = rand_addr(); d_wdata = rand_line();
            end
            if (!i_read && !d_read && !d_write) begin
                i_read = 1'b1; i_addr = rand_addr();
            end
            both  = i_read && (d_read || d_write);
            win_d = both ? ptr_d : (d_read || d_write);
`ifdef ARB_RR_EN
            if (both) ptr_d = !win_d;
`endif
            exp_addr = win_d ? d_addr : i_addr;
            exp_w    = win_d && d_write;
            exp_wd   = exp_w ? d_wdata : '0;
            @(negedge clk);
            for (int c = $urandom_range(0, 3); c >= 0; c--) begin
                checks++;
                if ({pmem_read, pmem_write, pmem_addr, pmem_wdata, i_resp, d_resp} !==
                    {!exp_w, exp_w, exp_addr, exp_wd, 2'b00}) begin
                    errors++;
                    $display("FAIL rand_cmd r%0d got rd=%0b wr=%0b addr=%h want rd=%0b wr=%0b addr=%h (win_d=%0b)",
                             r, pmem_read, pmem_write, pmem_addr, !exp_w, exp_w, exp_addr, win_d);
                end
                if (c > 0) begin
                    if (win_d) begin d_addr = rand_addr(); d_wdata = rand_line(); end
                    else i_addr = rand_addr();
                    @(negedge clk);
                end
            end
            rd = rand_line();
            pmem_rdata = rd;
            pmem_resp  = 1'b1;
            #1;
            checks++;
            if ({i_resp, d_resp} !== {!win_d, win_d} || (win_d ? d_rdata : i_rdata) !== rd) begin
                errors++;
                $display("FAIL rand_resp r%0d got ir=%0b dr=%0b want ir=%0b dr=%0b", r, i_resp, d_resp, !win_d, win_d);
            end
            @(negedge clk);
            pmem_resp = 1'b0;
            if (win_d) begin d_read = 1'b0; d_write = 1'b0; end
            else i_read = 1'b0;
            checks++;
            if ({pmem_read, pmem_write} !== 2'b00) begin
                errors++;
                $display("FAIL rand_turnaround r%0d got rd=%0b wr=%0b want 0 0", r, pmem_read, pmem_write);
            end
        end
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write_hold();
        test_both_pending();
        test_rw_both();
        test_idle_resp();
        test_reset_mid();
        test_random(300);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory line port between the L1 I-cache and the L1 D-cache of the 5-stage RV32I pipeline.
- Sits between both caches and the cacheline adaptor / physical memory.
- Grants one line transaction at a time: I-cache reads; D-cache reads and write-backs.
- Registers the granted command and holds it until memory responds, then routes the response to the owner.

Parameters:
ADDR_W, 32, byte address width of line requests (low 5 bits zero for line alignment)
LINE_W, 256, cache line width in bits

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
i_read  in  1  I-cache line read request, held until i_resp
i_addr  in  ADDR_W  I-cache line address
i_rdata  out  LINE_W  line data to I-cache, valid only while i_resp=1
i_resp  out  1  I-cache transaction done (one cycle)
d_read  in  1  D-cache line read request, held until d_resp
d_write  in  1  D-cache write-back request, held until d_resp
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  write-back line data
d_rdata  out  LINE_W  line data to D-cache, valid only while d_resp=1
d_resp  out  1  D-cache transaction done (one cycle)
pmem_read  out  1  memory read strobe, registered
pmem_write  out  1  memory write strobe, registered
pmem_addr  out  ADDR_W  memory address, registered
pmem_wdata  out  LINE_W  memory write data, registered
pmem_rdata  in  LINE_W  memory read data
pmem_resp  in  1  memory transaction done (one cycle)

Behaviour:
- Reset values (rst_n low, takes effect immediately, asynchronous):
  - state=IDLE.
  - pmem_read, pmem_write, pmem_addr, pmem_wdata = 0.
  - i_resp, d_resp = 0.
  - Priority pointer = D.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - Samples requests each cycle.
  - D pending (d_read|d_write) with I idle -> SERVE_D.
  - I pending with D idle -> SERVE_I.
  - Both pending -> D wins; fixed priority, the D-side instruction is older.
  - On the grant edge, capture pmem_addr, pmem_wdata (D write only, otherwise hold 0) and the strobe.
  - d_write=1 sets pmem_write; d_read alone sets pmem_read.
  - d_read and d_write both high is treated as a write.
- SERVE_x:
  - Strobes and captured address/data are held constant; requester input changes are ignored.
  - On pmem_resp=1: the owner's resp is driven high in that same cycle (combinational from pmem_resp and state), the owner's rdata = pmem_rdata, and next state = IDLE with strobes cleared.
- Latency:
  - Request visible at edge N -> strobe high from cycle N+1.
  - pmem_resp in cycle M -> requester resp in cycle M, strobes low in M+1, earliest next grant strobe in M+2.
  - The IDLE turnaround cycle is mandatory so the requester can drop its request.
- The non-owner's resp is always 0. i_rdata/d_rdata may be driven from pmem_rdata continuously; requesters qualify them with resp.
- pmem_resp in IDLE, including a stale one after a mid-transaction reset, is ignored: no resp to either side, no state change.
- A request arriving in the same cycle as the other side's resp is granted from the following IDLE cycle.
- No back-to-back grants without an intervening IDLE cycle.
- The I-cache has no write path.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined:
  - On each grant made while both sides were pending, the priority pointer flips to the side that lost, giving round-robin between I and D.
  - Grants made with only one side pending leave the pointer unchanged.
  - Pointer resets to D.
- Undefined: fixed D-over-I priority; no pointer register is instantiated.

Test Plan:
- Reset, then i_read=1, i_addr=0x0000_0060; memory responds 3 cycles after strobe with rdata=0xA5..A5 -> pmem_read=1, pmem_addr=0x60 from next cycle; i_resp=1 for one cycle with i_rdata=0xA5..A5; d_resp stays 0; strobe low next cycle.
- d_write=1, d_addr=0x0000_1000, d_wdata=0x1234..; d_addr changed to 0x2000 mid-transaction -> pmem_write=1, pmem_addr stays 0x1000 and pmem_wdata stays 0x1234.. until pmem_resp; then d_resp=1.
- i_read and d_read raised in the same cycle -> D served first; after d_resp, one IDLE cycle, then pmem_read for i_addr; with ARB_RR_EN, a second simultaneous pair is served I first.
- rst_n pulsed low while in SERVE_D with pmem_read=1 -> strobes drop without waiting for clk; a later stray pmem_resp produces no i_resp or d_resp.
- d_read=1 and d_write=1 simultaneously -> pmem_write=1, pmem_read=0.
- pmem_resp pulsed while IDLE with no requests -> no outputs change, state remains IDLE.
